fifo_unpacker: RTL and testbench

Read-side consumer for the team's show-ahead `fifo`. It pops `DWIDTH`-bit words from the FIFO head and serializes each word into `RATIO = DWIDTH/OWIDTH` narrower beats on a valid/ready stream. It sits between a wide buffering FIFO and a narrow downstream sink such as a byte-wide transmitter. At full downstream rate it sustains one beat per cycle with no bubble between words.

---
 rtl/fifo_unpacker_pkg.sv | 23 ++
 rtl/fifo.sv | 49 ++++
 rtl/fifo_unpacker.sv | 92 +++++++++
 tb/tb_fifo_unpacker.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_unpacker_pkg.sv
// Shared types and width helpers for the FIFO word unpacker.
package fifo_unpacker_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Beats per FIFO word.
  function automatic int unsigned unpack_ratio(input int unsigned dwidth,
                                               input int unsigned owidth);
    return (owidth == 0) ? 0 : dwidth / owidth;
  endfunction

  // Slice counter width; a single-beat word still gets a 1-bit counter.
  function automatic int unsigned unpack_cnt_width(input int unsigned dwidth,
                                                   input int unsigned owidth);
    int unsigned ratio;
    ratio = unpack_ratio(dwidth, owidth);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/fifo.sv
// Show-ahead synchronous FIFO: q_o presents the head word whenever empty_o is low.
module fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             wrreq_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             rdreq_i,
  output logic [WIDTH-1:0] q_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr;
  logic             do_rd;

  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == (AW+1)'(DEPTH));
    do_wr   = wrreq_i && !full_o;
    do_rd   = rdreq_i && !empty_o;
    q_o     = mem[rd_ptr_q];
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr && !srst_i) mem[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fifo_unpacker.sv
// Pops wide words from a show-ahead FIFO and streams them out as narrow
// valid/ready beats, popping the next word on the final beat to avoid bubbles.
module fifo_unpacker
  import fifo_unpacker_pkg::*;
#(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned OWIDTH    = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rdreq_o,
  output logic [OWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o,
  output logic              busy_o
);

  localparam int unsigned RATIO    = unpack_ratio(DWIDTH, OWIDTH);
  localparam int unsigned CW       = unpack_cnt_width(DWIDTH, OWIDTH);
  localparam int unsigned IW       = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

  generate
    if (OWIDTH == 0 || (DWIDTH % OWIDTH) != 0) begin : g_width_check
      $error("fifo_unpacker: DWIDTH must be a multiple of OWIDTH");
    end
  endgenerate

  state_t            state_q, state_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic [DWIDTH-1:0] word_q, word_n;
  logic [OWIDTH-1:0] data_q, data_n;
  logic              valid_q;
  logic              last_q;
  logic              beat;
  logic              at_last;
  logic              take;
  int unsigned       sel;
  logic [IW-1:0]     lsb;

  always_comb begin
    beat         = valid_q && ready_i;
    at_last      = (cnt_q == CNT_LAST);
    take         = (state_q == IDLE) || (beat && at_last);
    fifo_rdreq_o = take && !fifo_empty_i && arstn_i;

    state_n = state_q;
    cnt_n   = cnt_q;
    word_n  = word_q;
    if (fifo_rdreq_o) begin
      word_n  = fifo_q_i;
      cnt_n   = '0;
      state_n = SEND;
    end else if (beat) begin
      if (at_last) state_n = IDLE;
      else         cnt_n   = cnt_q + CW'(1);
    end

    // Output slice is computed from the next word/count so data_o is a flop.
    sel    = MSB_FIRST ? (RATIO - 1 - 32'(cnt_n)) : 32'(cnt_n);
    lsb    = IW'(sel * OWIDTH);
    data_n = word_n[lsb +: OWIDTH];
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      word_q  <= word_n;
      data_q  <= data_n;
      valid_q <= (state_n == SEND);
      last_q  <= (state_n == SEND) && (cnt_n == CNT_LAST);
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign busy_o  = valid_q;

endmodule

// File: tb/tb_fifo_unpacker.sv
// Self-checking bench: two fifo+unpacker pairs (LSB-first and MSB-first) fed from a vector table.
module tb_fifo_unpacker;
  import fifo_unpacker_pkg::*;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        ready = 1'b0;
  logic        wr_l = 1'b0;
  logic        wr_m = 1'b0;
  logic [31:0] wdata = '0;
  logic        sel_m = 1'b0;
  logic [1:0]  rst_sync;
  logic        srst;

  logic [31:0] q_l, q_m;
  logic        empty_l, empty_m, full_l, full_m, rdreq_l, rdreq_m;
  logic [7:0]  data_l, data_m;
  logic        valid_l, valid_m, last_l, last_m, busy_l, busy_m;

  logic        x_valid, x_last, x_rdreq, x_busy;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  typedef struct packed {
    logic [31:0] word;
    logic        msb;
    logic [31:0] seq;   // expected beats in send order, first beat in [31:24]
  } vec_t;

  beat_t sb_l[$];
  beat_t sb_m[$];
  vec_t  vecs[9];
  int    checks = 0;
  int    errors = 0;

  initial forever #5 clk = ~clk;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) rst_sync <= 2'b11;
    else        rst_sync <= {rst_sync[0], 1'b0};
  end
  assign srst = rst_sync[1];

  fifo #(.WIDTH(32), .DEPTH(8)) fifo_l (
    .clk_i(clk), .srst_i(srst), .wrreq_i(wr_l), .data_i(wdata),
    .rdreq_i(rdreq_l), .q_o(q_l), .empty_o(empty_l), .full_o(full_l)
  );

  fifo_unpacker #(.DWIDTH(32), .OWIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk_i(clk), .arstn_i(arstn), .fifo_q_i(q_l), .fifo_empty_i(empty_l),
    .fifo_rdreq_o(rdreq_l), .data_o(data_l), .valid_o(valid_l),
    .ready_i(ready), .last_o(last_l), .busy_o(busy_l)
  );

  fifo #(.WIDTH(32), .DEPTH(8)) fifo_m (
    .clk_i(clk), .srst_i(srst), .wrreq_i(wr_m), .data_i(wdata),
    .rdreq_i(rdreq_m), .q_o(q_m), .empty_o(empty_m), .full_o(full_m)
  );

  fifo_unpacker #(.DWIDTH(32), .OWIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk_i(clk), .arstn_i(arstn), .fifo_q_i(q_m), .fifo_empty_i(empty_m),
    .fifo_rdreq_o(rdreq_m), .data_o(data_m), .valid_o(valid_m),
    .ready_i(ready), .last_o(last_m), .busy_o(busy_m)
  );

  always_comb begin
    x_valid = sel_m ? valid_m : valid_l;
    x_last  = sel_m ? last_m  : last_l;
    x_rdreq = sel_m ? rdreq_m : rdreq_l;
    x_busy  = sel_m ? busy_m  : busy_l;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_seq(input logic m, input logic [31:0] seq);
    for (int k = 0; k < 4; k++) begin
      beat_t b;
      b.d = seq[31-8*k -: 8];
      b.l = (k == 3);
      if (m) sb_m.push_back(b);
      else   sb_l.push_back(b);
    end
  endtask

  // A beat is taken at the next rising edge whenever valid and ready are both high now.
  task automatic sb_sample();
    if (arstn && valid_l && ready) begin
      if (sb_l.size() == 0) begin
        checks++; errors++;
        $display("FAIL beat_l_unexpected: got %0h expected none", data_l);
      end else begin
        beat_t e;
        e = sb_l.pop_front();
        chk("beat_l_data", {24'd0, data_l}, {24'd0, e.d});
        chk("beat_l_last", {31'd0, last_l}, {31'd0, e.l});
      end
    end
    if (arstn && valid_m && ready) begin
      if (sb_m.size() == 0) begin
        checks++; errors++;
        $display("FAIL beat_m_unexpected: got %0h expected none", data_m);
      end else begin
        beat_t e;
        e = sb_m.pop_front();
        chk("beat_m_data", {24'd0, data_m}, {24'd0, e.d});
        chk("beat_m_last", {31'd0, last_m}, {31'd0, e.l});
      end
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
    sb_sample();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic m, input logic [31:0] w, input logic [31:0] seq);
    wdata = w;
    if (m) wr_m = 1'b1;
    else   wr_l = 1'b1;
    push_seq(m, seq);
    to_neg();
    to_pos();
    wr_l = 1'b0;
    wr_m = 1'b0;
  endtask

  // Bit i of v/l/r is the expected valid/last/rdreq in the i-th cycle from now.
  task automatic run_expect(input string nm, input int n,
                            input logic [15:0] v, input logic [15:0] l, input logic [15:0] r);
    for (int i = 0; i < n; i++) begin
      to_neg();
      chk({nm, "_valid"}, {31'd0, x_valid}, {31'd0, v[i]});
      chk({nm, "_last"},  {31'd0, x_last},  {31'd0, l[i]});
      chk({nm, "_rdreq"}, {31'd0, x_rdreq}, {31'd0, r[i]});
      chk({nm, "_busy"},  {31'd0, x_busy},  {31'd0, v[i]});
      to_pos();
    end
  endtask

  task automatic stall_chk();
    to_neg();
    chk("bp_data",  {24'd0, data_l},  32'hBB);
    chk("bp_valid", {31'd0, valid_l}, 32'd1);
    chk("bp_last",  {31'd0, last_l},  32'd0);
    chk("bp_rdreq", {31'd0, rdreq_l}, 32'd0);
    chk("bp_cnt",   32'(dut_l.cnt_q), 32'd1);
    to_pos();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{word: 32'h44332211, msb: 1'b0, seq: 32'h11223344};
    vecs[1] = '{word: 32'hDDCCBBAA, msb: 1'b0, seq: 32'hAABBCCDD};
    vecs[2] = '{word: 32'h00000000, msb: 1'b0, seq: 32'h00000000};
    vecs[3] = '{word: 32'hFFFFFFFF, msb: 1'b0, seq: 32'hFFFFFFFF};
    vecs[4] = '{word: 32'h12345678, msb: 1'b0, seq: 32'h78563412};
    vecs[5] = '{word: 32'hA5C3E10F, msb: 1'b0, seq: 32'h0FE1C3A5};
    vecs[6] = '{word: 32'hDDCCBBAA, msb: 1'b1, seq: 32'hDDCCBBAA};
    vecs[7] = '{word: 32'h80000001, msb: 1'b1, seq: 32'h80000001};
    vecs[8] = '{word: 32'h0F1E2D3C, msb: 1'b1, seq: 32'h0F1E2D3C};

    // Reset state
    to_neg();
    chk("rst_valid", {31'd0, valid_l}, 32'd0);
    chk("rst_data",  {24'd0, data_l},  32'd0);
    chk("rst_last",  {31'd0, last_l},  32'd0);
    chk("rst_busy",  {31'd0, busy_l},  32'd0);
    chk("rst_rdreq", {31'd0, rdreq_l}, 32'd0);
    chk("rst_state", 32'(dut_l.state_q), 32'(IDLE));
    chk("rst_cnt",   32'(dut_l.cnt_q), 32'd0);
    chk("rst_word",  dut_l.word_q, 32'd0);
    chk("rst_valid_m", {31'd0, valid_m}, 32'd0);
    chk("rst_full",  {31'd0, full_l | full_m}, 32'd0);
    to_pos();
    arstn = 1'b1;
    run_expect("release", 3, 16'd0, 16'd0, 16'd0);

    // Table: each word from idle, with ready held high
    ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      sel_m = vecs[i].msb;
      run_expect("idle", 2, 16'd0, 16'd0, 16'd0);
      write_word(vecs[i].msb, vecs[i].word, vecs[i].seq);
      run_expect("vec", 6, 16'b011110, 16'b010000, 16'b000001);
      chk("vec_state_idle", 32'(sel_m ? dut_m.state_q : dut_l.state_q), 32'(IDLE));
    end
    sel_m = 1'b0;

    // Back-to-back words: no bubble, pop coincides with the last beat of word 0
    ready = 1'b0;
    write_word(1'b0, 32'h44332211, 32'h11223344);
    write_word(1'b0, 32'h88776655, 32'h55667788);
    ready = 1'b1;
    run_expect("b2b", 9, 16'b011111111, 16'b010001000, 16'b000001000);

    // Backpressure on beat BB with the FIFO non-empty
    write_word(1'b0, 32'hDDCCBBAA, 32'hAABBCCDD);
    run_expect("bp_pre", 2, 16'b10, 16'b00, 16'b01);
    ready = 1'b0;
    wdata = 32'h12345678;
    wr_l  = 1'b1;
    push_seq(1'b0, 32'h78563412);
    stall_chk();
    wr_l = 1'b0;
    stall_chk();
    stall_chk();
    ready = 1'b1;
    run_expect("bp_post", 8, 16'b01111111, 16'b01000100, 16'b00000100);

    // Asynchronous reset mid-word with another word still queued
    write_word(1'b0, 32'hDDCCBBAA, 32'hAABBCCDD);
    write_word(1'b0, 32'h12345678, 32'h78563412);
    run_expect("ar_pre", 2, 16'b11, 16'b00, 16'b00);
    arstn = 1'b0;
    sb_l.delete();
    #1;
    chk("ar_valid", {31'd0, valid_l}, 32'd0);
    chk("ar_data",  {24'd0, data_l},  32'd0);
    chk("ar_last",  {31'd0, last_l},  32'd0);
    chk("ar_busy",  {31'd0, busy_l},  32'd0);
    chk("ar_fifo_nonempty", {31'd0, empty_l}, 32'd0);
    chk("ar_rdreq", {31'd0, rdreq_l}, 32'd0);
    run_expect("ar_hold", 2, 16'd0, 16'd0, 16'd0);
    arstn = 1'b1;
    run_expect("ar_rel", 3, 16'd0, 16'd0, 16'd0);
    write_word(1'b0, 32'h000000EE, 32'hEE000000);
    run_expect("ar_new", 6, 16'b011110, 16'b010000, 16'b000001);

    chk("sb_l_drained", 32'(sb_l.size()), 32'd0);
    chk("sb_m_drained", 32'(sb_m.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
